parser_extract_phv: RTL and testbench

- Stage directly downstream of the segment-collecting parser front end.
- Consumes the captured packet header (up to 4x256-bit segments), the first-beat tuser, and the 160-bit parse-action word fetched for that packet.
- Executes the 10 parse actions to build a packet header vector (PHV), then presents the PHV to the first match stage through a valid/ready handshake with a 2-entry output buffer.

---
 rtl/parser_extract_phv_if.sv | 50 +++++
 rtl/parser_extract_phv.sv | 166 ++++++++++++++++
 tb/tb_parser_extract_phv.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parser_extract_phv_if.sv
// ---------------------------------------------------------------------------
// parser_extract_phv_if
//
// Purpose: bundles the header/action input bus and the PHV output handshake
// of parser_extract_phv.
//
// Signals:
//   tdata_segs       captured header, wire byte k at bits [8*k+:8]
//   tuser_1st        first-beat tuser of the packet
//   segs_valid       one-cycle pulse; header/tuser/actions valid this cycle
//   parser_bram_out  parse-action word, action i at bits [16*i+:16]
//   phv_out          head of the output buffer (zero when empty)
//   phv_valid        head of the output buffer holds a PHV
//   phv_ready        consumer takes phv_out this cycle
//   drop_cnt         saturating count of PHVs lost to a full buffer
//
// Handshake: a PHV transfers on every rising clock edge where phv_valid and
// phv_ready are both high. Once phv_valid is high, it stays high and phv_out
// stays stable until that transfer. phv_ready may change freely and never
// depends on phv_valid. segs_valid has no ready; the block always takes it.
//
// Modports: master = producer of header/actions and consumer of the PHV,
//           slave  = parser_extract_phv itself.
// ---------------------------------------------------------------------------
interface parser_extract_phv_if #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_SEGS         = 4,
  parameter int C_PARSER_RAM_WIDTH = 160,
  parameter int C_PHV_WIDTH        = 896
);
  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] tdata_segs;
  logic [C_AXIS_TUSER_WIDTH-1:0]           tuser_1st;
  logic                                    segs_valid;
  logic [C_PARSER_RAM_WIDTH-1:0]           parser_bram_out;
  logic [C_PHV_WIDTH-1:0]                  phv_out;
  logic                                    phv_valid;
  logic                                    phv_ready;
  logic [15:0]                             drop_cnt;

  modport master (
    output tdata_segs, tuser_1st, segs_valid, parser_bram_out, phv_ready,
    input  phv_out, phv_valid, drop_cnt
  );

  modport slave (
    input  tdata_segs, tuser_1st, segs_valid, parser_bram_out, phv_ready,
    output phv_out, phv_valid, drop_cnt
  );
endinterface

// File: rtl/parser_extract_phv.sv
// ---------------------------------------------------------------------------
// parser_extract_phv
//
// Purpose: runs the 10 parse actions over a captured 128-byte header to build
// the packet header vector (PHV) and hands it to the first match stage via a
// 2-entry output buffer.
//
// Ports:
//   axis_clk  clock
//   aresetn   asynchronous active-low reset; clears valid bits, buffer and
//             drop counter, discarding anything in flight
//   bus       parser_extract_phv_if.slave (header/actions in, PHV out)
//
// Pipeline: S0 registers the inputs on segs_valid. S1 extracts from the S0
// registers combinationally and its result is written straight into the
// output buffer, so a PHV is at the buffer head two cycles after segs_valid.
//
// Action word (16b): [15:9] byte offset, [8:7] type (00=16b 01=32b 10=48b
// 11=ignored), [6:4] container index, [3:1] reserved, [0] valid.
// PHV layout, MSB first: {c48[7..0], c32[7..0], c16[7..0], tuser}.
// ---------------------------------------------------------------------------
module parser_extract_phv #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_SEGS         = 4,
  parameter int C_PARSER_RAM_WIDTH = 160,
  parameter int C_PHV_WIDTH        = 896
) (
  input logic                  axis_clk,
  input logic                  aresetn,
  parser_extract_phv_if.slave  bus
);
  localparam int HDR_W    = C_NUM_SEGS * C_AXIS_DATA_WIDTH;
  localparam int NUM_ACTS = C_PARSER_RAM_WIDTH / 16;
  localparam int T_W      = C_AXIS_TUSER_WIDTH;
  localparam int C16_LSB  = T_W;
  localparam int C32_LSB  = T_W + 8 * 16;
  localparam int C48_LSB  = T_W + 8 * 16 + 8 * 32;

  // Header byte at offset+j; bytes past the 128-byte header read as zero.
  function automatic logic [7:0] hdr_byte(input logic [HDR_W-1:0] hdr,
                                          input logic [6:0] off,
                                          input logic [2:0] j);
    logic [7:0] pos;
    pos = {1'b0, off} + {5'b0, j};
    if (pos[7]) hdr_byte = 8'h00;
    else        hdr_byte = hdr[{pos[6:0], 3'b000} +: 8];
  endfunction

  // ---------------- S0: input registers ----------------
  logic                          s0_vld_q;
  logic [HDR_W-1:0]              segs_q;
  logic [T_W-1:0]                tuser_q;
  logic [C_PARSER_RAM_WIDTH-1:0] acts_q;

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) s0_vld_q <= 1'b0;
    else          s0_vld_q <= bus.segs_valid;
  end

  // Data registers need no reset: they are only consumed under s0_vld_q.
  always_ff @(posedge axis_clk) begin
    if (bus.segs_valid) begin
      segs_q  <= bus.tdata_segs;
      tuser_q <= bus.tuser_1st;
      acts_q  <= bus.parser_bram_out;
    end
  end

  // ---------------- S1: extraction ----------------
  logic                   s1_vld;
  logic [C_PHV_WIDTH-1:0] phv_s1;
  logic [15:0]            c16 [8];
  logic [31:0]            c32 [8];
  logic [47:0]            c48 [8];

  assign s1_vld = s0_vld_q;

  // Actions run in ascending order and each overwrites its whole container,
  // so the highest-indexed action targeting a container wins.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      c16[k] = '0;
      c32[k] = '0;
      c48[k] = '0;
    end
    for (int i = 0; i < NUM_ACTS; i++) begin
      if (acts_q[16*i]) begin
        case (acts_q[16*i+7 +: 2])
          2'b00: c16[acts_q[16*i+4 +: 3]] = {
                   hdr_byte(segs_q, acts_q[16*i+9 +: 7], 3'd0),
                   hdr_byte(segs_q, acts_q[16*i+9 +: 7], 3'd1)};
          2'b01: c32[acts_q[16*i+4 +: 3]] = {
                   hdr_byte(segs_q, acts_q[16*i+9 +: 7], 3'd0),
                   hdr_byte(segs_q, acts_q[16*i+9 +: 7], 3'd1),
                   hdr_byte(segs_q, acts_q[16*i+9 +: 7], 3'd2),
                   hdr_byte(segs_q, acts_q[16*i+9 +: 7], 3'd3)};
          2'b10: c48[acts_q[16*i+4 +: 3]] = {
                   hdr_byte(segs_q, acts_q[16*i+9 +: 7], 3'd0),
                   hdr_byte(segs_q, acts_q[16*i+9 +: 7], 3'd1),
                   hdr_byte(segs_q, acts_q[16*i+9 +: 7], 3'd2),
                   hdr_byte(segs_q, acts_q[16*i+9 +: 7], 3'd3),
                   hdr_byte(segs_q, acts_q[16*i+9 +: 7], 3'd4),
                   hdr_byte(segs_q, acts_q[16*i+9 +: 7], 3'd5)};
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    phv_s1 = '0;
    phv_s1[T_W-1:0] = tuser_q;
    for (int k = 0; k < 8; k++) begin
      phv_s1[C16_LSB + 16*k +: 16] = c16[k];
      phv_s1[C32_LSB + 32*k +: 32] = c32[k];
      phv_s1[C48_LSB + 48*k +: 48] = c48[k];
    end
  end

  // ---------------- Output buffer (2 entries) ----------------
  logic [C_PHV_WIDTH-1:0] mem_q [2];
  logic [1:0]             cnt_q, cnt_d;
  logic                   rd_q, rd_d, wr_q, wr_d;
  logic [15:0]            drop_q, drop_d;
  logic                   pop, full, accept, drop;

  always_comb begin
    pop    = (cnt_q != 2'd0) && bus.phv_ready;
    full   = (cnt_q == 2'd2);
    // A full buffer still accepts when its head leaves in the same cycle.
    accept = s1_vld && (!full || pop);
    drop   = s1_vld && full && !pop;
    cnt_d  = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + 2'd1;
    else if (!accept && pop) cnt_d = cnt_q - 2'd1;
    wr_d   = wr_q ^ accept;
    rd_d   = rd_q ^ pop;
    drop_d = drop_q;
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q  <= 2'd0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      drop_q <= 16'd0;
    end else begin
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      drop_q <= drop_d;
    end
  end

  // When full with a pop, wr_q equals rd_q: the head is overwritten at the
  // same edge it leaves, which is safe because phv_out is read before it.
  always_ff @(posedge axis_clk) begin
    if (accept) mem_q[wr_q] <= phv_s1;
  end

  assign bus.phv_valid = (cnt_q != 2'd0);
  assign bus.phv_out   = (cnt_q != 2'd0) ? mem_q[rd_q] : '0;
  assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_parser_extract_phv.sv
module tb_parser_extract_phv;
  localparam int HDR_W = 1024;
  localparam int PHV_W = 896;

  logic axis_clk;
  logic aresetn;

  parser_extract_phv_if #(
    .C_AXIS_DATA_WIDTH(256), .C_AXIS_TUSER_WIDTH(128), .C_NUM_SEGS(4),
    .C_PARSER_RAM_WIDTH(160), .C_PHV_WIDTH(896)
  ) bus ();

  parser_extract_phv #(
    .C_AXIS_DATA_WIDTH(256), .C_AXIS_TUSER_WIDTH(128), .C_NUM_SEGS(4),
    .C_PARSER_RAM_WIDTH(160), .C_PHV_WIDTH(896)
  ) dut (
    .axis_clk (axis_clk),
    .aresetn  (aresetn),
    .bus      (bus)
  );

  // ---------------- clock / reset ----------------
  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [PHV_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int exp_drop = 0;

  // Reference PHV built byte by byte from the header.
  function automatic logic [PHV_W-1:0] model_phv(input logic [HDR_W-1:0] hdr,
                                                 input logic [127:0] tu,
                                                 input logic [159:0] acts);
    logic [7:0]  b [128];
    logic [15:0] m16 [8];
    logic [31:0] m32 [8];
    logic [47:0] m48 [8];
    logic [15:0] a;
    logic [47:0] val;
    logic [PHV_W-1:0] p;
    int off, len, ix;
    for (int k = 0; k < 128; k++) b[k] = hdr[8*k +: 8];
    for (int k = 0; k < 8; k++) begin m16[k] = '0; m32[k] = '0; m48[k] = '0; end
    for (int i = 0; i < 10; i++) begin
      a   = acts[16*i +: 16];
      off = int'(a[15:9]);
      ix  = int'(a[6:4]);
      case (a[8:7])
        2'b00: len = 2;
        2'b01: len = 4;
        2'b10: len = 6;
        default: len = 0;
      endcase
      if (a[0] && len != 0) begin
        val = '0;
        for (int j = 0; j < len; j++)
          val = (val << 8) | ((off + j < 128) ? {40'd0, b[off + j]} : 48'd0);
        if (len == 2) m16[ix] = val[15:0];
        else if (len == 4) m32[ix] = val[31:0];
        else m48[ix] = val;
      end
    end
    p = '0;
    p[127:0] = tu;
    for (int k = 0; k < 8; k++) begin
      p[128 + 16*k +: 16] = m16[k];
      p[256 + 32*k +: 32] = m32[k];
      p[512 + 48*k +: 48] = m48[k];
    end
    return p;
  endfunction

  function automatic logic [HDR_W-1:0] mk_incr();
    logic [HDR_W-1:0] h;
    for (int k = 0; k < 128; k++) h[8*k +: 8] = 8'(k);
    return h;
  endfunction

  function automatic logic [HDR_W-1:0] mk_rand_hdr();
    logic [HDR_W-1:0] h;
    for (int k = 0; k < 32; k++) h[32*k +: 32] = $urandom;
    return h;
  endfunction

  function automatic logic [127:0] mk_rand_tu();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [159:0] mk_rand_acts();
    logic [159:0] a;
    for (int i = 0; i < 10; i++)
      a[16*i +: 16] = {7'($urandom_range(0, 127)), 2'($urandom_range(0, 3)),
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 3) != 0)};
    return a;
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; leaves segs_valid high for one cycle.
  task automatic drive_segs(input logic [HDR_W-1:0] hdr, input logic [127:0] tu,
                            input logic [159:0] acts);
    bus.tdata_segs      = hdr;
    bus.tuser_1st       = tu;
    bus.parser_bram_out = acts;
    bus.segs_valid      = 1'b1;
    exp_q.push_back(model_phv(hdr, tu, acts));
    @(posedge axis_clk);
    #1;
    bus.segs_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    aresetn = 1'b0;
    bus.segs_valid = 1'b0;
    bus.phv_ready = 1'b0;
    bus.tdata_segs = '0;
    bus.tuser_1st = '0;
    bus.parser_bram_out = '0;
    repeat (2) @(negedge axis_clk);
    n_checks++;
    if (bus.phv_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.phv_valid);
    else n_pass++;
    n_checks++;
    if (bus.phv_out !== '0) $display("FAIL reset_phv_out got nonzero %h", bus.phv_out);
    else n_pass++;
    n_checks++;
    if (bus.drop_cnt !== 16'd0) $display("FAIL reset_drop got %0d want 0", bus.drop_cnt);
    else n_pass++;
    aresetn = 1'b1;
    @(posedge axis_clk);
    #1;
  endtask

  task automatic test_extract48();
    logic [127:0] tu;
    logic [159:0] acts;
    logic [PHV_W-1:0] e;
    tu = mk_rand_tu();
    acts = '0;
    acts[15:0] = 16'h0B01;  // offset 5, 48b, container 0, valid
    bus.phv_ready = 1'b1;
    drive_segs(mk_incr(), tu, acts);
    @(negedge axis_clk);
    n_checks++;
    if (bus.phv_valid !== 1'b0) $display("FAIL e48_early got %b want 0", bus.phv_valid);
    else n_pass++;
    @(negedge axis_clk);
    n_checks++;
    if (bus.phv_valid !== 1'b1) $display("FAIL e48_valid got %b want 1", bus.phv_valid);
    else n_pass++;
    n_checks++;
    if (bus.phv_out[512 +: 48] !== 48'h05060708090A)
      $display("FAIL e48_c48_0 got %h want 05060708090a", bus.phv_out[512 +: 48]);
    else n_pass++;
    n_checks++;
    if (bus.phv_out[127:0] !== tu) $display("FAIL e48_tuser got %h want %h", bus.phv_out[127:0], tu);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.phv_out !== e) $display("FAIL e48_phv got %h want %h", bus.phv_out, e);
    else n_pass++;
    @(negedge axis_clk);
    n_checks++;
    if (bus.phv_valid !== 1'b0) $display("FAIL e48_drain got %b want 0", bus.phv_valid);
    else n_pass++;
    @(posedge axis_clk);
    #1;
  endtask

  task automatic test_out_of_range();
    logic [159:0] acts;
    logic [PHV_W-1:0] e;
    acts = '0;
    acts[15:0] = 16'hFC81;  // offset 126, 32b, container 0, valid
    bus.phv_ready = 1'b1;
    drive_segs(mk_incr(), mk_rand_tu(), acts);
    repeat (2) @(negedge axis_clk);
    n_checks++;
    if (bus.phv_out[256 +: 32] !== 32'h7E7F0000)
      $display("FAIL oob_c32_0 got %h want 7e7f0000", bus.phv_out[256 +: 32]);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.phv_out !== e) $display("FAIL oob_phv got %h want %h", bus.phv_out, e);
    else n_pass++;
    @(posedge axis_clk);
    #1;
  endtask

  task automatic test_priority();
    logic [HDR_W-1:0] hdr;
    logic [159:0] acts;
    logic [PHV_W-1:0] e;
    hdr = mk_rand_hdr();
    acts = '0;
    acts[16*2 +: 16] = 16'h0031;  // offset 0, 16b, container 3
    acts[16*4 +: 16] = 16'h01B1;  // type 11 on container 3: ignored
    acts[16*5 +: 16] = 16'h0830;  // valid bit clear: ignored
    acts[16*7 +: 16] = 16'h1431;  // offset 10, 16b, container 3
    bus.phv_ready = 1'b1;
    drive_segs(hdr, mk_rand_tu(), acts);
    repeat (2) @(negedge axis_clk);
    n_checks++;
    if (bus.phv_out[128 + 48 +: 16] !== {hdr[8*10 +: 8], hdr[8*11 +: 8]})
      $display("FAIL prio_c16_3 got %h want %h", bus.phv_out[176 +: 16],
               {hdr[8*10 +: 8], hdr[8*11 +: 8]});
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.phv_out !== e) $display("FAIL prio_phv got %h want %h", bus.phv_out, e);
    else n_pass++;
    @(posedge axis_clk);
    #1;
  endtask

  task automatic test_back_to_back();
    bus.phv_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) drive_segs(mk_rand_hdr(), mk_rand_tu(), mk_rand_acts());
      end
      begin
        int c;
        logic [PHV_W-1:0] e;
        c = 0;
        @(negedge axis_clk);
        while (!bus.phv_valid && c < 10) begin @(negedge axis_clk); c++; end
        for (int i = 0; i < 6; i++) begin
          n_checks++;
          if (bus.phv_valid !== 1'b1) $display("FAIL b2b_valid_%0d got %b want 1", i, bus.phv_valid);
          else n_pass++;
          e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
          n_checks++;
          if (bus.phv_out !== e) $display("FAIL b2b_phv_%0d got %h want %h", i, bus.phv_out, e);
          else n_pass++;
          @(negedge axis_clk);
        end
        n_checks++;
        if (bus.phv_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", bus.phv_valid);
        else n_pass++;
      end
    join
    @(posedge axis_clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [PHV_W-1:0] e;
    bus.phv_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_segs(mk_rand_hdr(), mk_rand_tu(), mk_rand_acts());
    e = exp_q.pop_back();  // third PHV finds the buffer full
    exp_drop++;
    @(posedge axis_clk);
    #1;
    @(negedge axis_clk);
    n_checks++;
    if (bus.phv_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", bus.phv_valid);
    else n_pass++;
    n_checks++;
    if (bus.drop_cnt !== 16'(exp_drop)) $display("FAIL bp_drop got %0d want %0d", bus.drop_cnt, exp_drop);
    else n_pass++;
    bus.phv_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (bus.phv_valid !== 1'b1 || bus.phv_out !== e)
        $display("FAIL bp_order_%0d got v=%b %h want %h", i, bus.phv_valid, bus.phv_out, e);
      else n_pass++;
      @(negedge axis_clk);
    end
    n_checks++;
    if (bus.phv_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", bus.phv_valid);
    else n_pass++;
    @(posedge axis_clk);
    #1;
  endtask

  task automatic test_push_pop_same();
    logic [PHV_W-1:0] e;
    bus.phv_ready = 1'b0;
    drive_segs(mk_rand_hdr(), mk_rand_tu(), mk_rand_acts());
    drive_segs(mk_rand_hdr(), mk_rand_tu(), mk_rand_acts());
    @(posedge axis_clk);
    #1;
    // Buffer is now full; this PHV lands on the edge where the head leaves.
    drive_segs(mk_rand_hdr(), mk_rand_tu(), mk_rand_acts());
    bus.phv_ready = 1'b1;
    @(negedge axis_clk);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.phv_out !== e) $display("FAIL pp_head got %h want %h", bus.phv_out, e);
    else n_pass++;
    @(posedge axis_clk);
    #1;
    bus.phv_ready = 1'b0;
    @(negedge axis_clk);
    n_checks++;
    if (bus.drop_cnt !== 16'(exp_drop)) $display("FAIL pp_drop got %0d want %0d", bus.drop_cnt, exp_drop);
    else n_pass++;
    bus.phv_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (bus.phv_valid !== 1'b1 || bus.phv_out !== e)
        $display("FAIL pp_order_%0d got v=%b %h want %h", i, bus.phv_valid, bus.phv_out, e);
      else n_pass++;
      @(negedge axis_clk);
    end
    n_checks++;
    if (bus.phv_valid !== 1'b0) $display("FAIL pp_empty got %b want 0", bus.phv_valid);
    else n_pass++;
    @(posedge axis_clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int seen;
    logic [PHV_W-1:0] e;
    bus.phv_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_segs(mk_rand_hdr(), mk_rand_tu(), mk_rand_acts());
    // Two PHVs buffered, third sitting in S1.
    #2;
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (bus.phv_valid !== 1'b0) $display("FAIL rm_valid got %b want 0", bus.phv_valid);
    else n_pass++;
    n_checks++;
    if (bus.phv_out !== '0) $display("FAIL rm_phv_out got nonzero %h", bus.phv_out);
    else n_pass++;
    n_checks++;
    if (bus.drop_cnt !== 16'd0) $display("FAIL rm_drop got %0d want 0", bus.drop_cnt);
    else n_pass++;
    exp_q.delete();
    exp_drop = 0;
    @(negedge axis_clk);
    aresetn = 1'b1;
    bus.phv_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge axis_clk);
      if (bus.phv_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL rm_stale got %0d valid cycles want 0", seen);
    else n_pass++;
    n_checks++;
    if (bus.drop_cnt !== 16'(exp_drop)) $display("FAIL rm_drop_after got %0d want 0", bus.drop_cnt);
    else n_pass++;
    @(posedge axis_clk);
    #1;
    drive_segs(mk_rand_hdr(), mk_rand_tu(), mk_rand_acts());
    repeat (2) @(negedge axis_clk);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.phv_valid !== 1'b1 || bus.phv_out !== e)
      $display("FAIL rm_resume got v=%b %h want %h", bus.phv_valid, bus.phv_out, e);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_extract48();
    test_out_of_range();
    test_priority();
    test_back_to_back();
    test_backpressure();
    test_push_pop_same();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
